// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Register-specifier width, FSM state encoding and the ID/EX bubble encoding.
package hazard_pkg;

    localparam int REG_W = 3;

    // Instruction word that the ID/EX bubble represents (all-zero word decodes as a no-op).
    localparam logic [31:0] NOP_INSN = 32'h0000_0000;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    function automatic logic regHit(input logic uses, input logic [REG_W-1:0] src,
                                    input logic [REG_W-1:0] dst);
        return uses && (src == dst);
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side signal bundle of the hazard controller.
// master = pipeline (drives hazard inputs), slave = hazard_ctrl (drives stall controls).
interface hazard_ctrl_if;
    import hazard_pkg::*;

    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rqrd;
    logic             id_uses_rs;
    logic             id_uses_rqrd;
    logic [REG_W-1:0] ex_rd;
    logic             ex_mem_read;
    logic             ex_write_en;
    logic             branch_taken;
    logic             mem_req;
    logic             mem_ready;
    logic             pc_stall;
    logic             ifid_stall;
    logic             idex_bubble;
    logic             ifid_flush;
    logic             pipe_freeze;
    logic             mem_timeout_err;
    logic [31:0]      perf_lu_stalls;
    logic [31:0]      perf_mem_wait;
    logic [31:0]      perf_flushes;

    modport master (
        output id_rs, id_rqrd, id_uses_rs, id_uses_rqrd, ex_rd, ex_mem_read, ex_write_en,
               branch_taken, mem_req, mem_ready,
        input  pc_stall, ifid_stall, idex_bubble, ifid_flush, pipe_freeze, mem_timeout_err,
               perf_lu_stalls, perf_mem_wait, perf_flushes
    );

    modport slave (
        input  id_rs, id_rqrd, id_uses_rs, id_uses_rqrd, ex_rd, ex_mem_read, ex_write_en,
               branch_taken, mem_req, mem_ready,
        output pc_stall, ifid_stall, idex_bubble, ifid_flush, pipe_freeze, mem_timeout_err,
               perf_lu_stalls, perf_mem_wait, perf_flushes
    );

endinterface

// File: rtl/hazard_perf_cnt.sv
// Hazard performance counters: load-use stall, memory-wait and flush cycles.
// Latency: counts visible the cycle after the event. No backpressure; counters wrap mod 2^32.
module hazard_perf_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        luStall,
    input  logic        freeze,
    input  logic        flush,
    output logic [31:0] luCnt,
    output logic [31:0] waitCnt,
    output logic [31:0] flushCnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            luCnt    <= '0;
            waitCnt  <= '0;
            flushCnt <= '0;
        end else begin
            if (luStall) luCnt    <= luCnt + 32'd1;
            if (freeze)  waitCnt  <= waitCnt + 32'd1;
            if (flush)   flushCnt <= flushCnt + 32'd1;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, memory-wait freeze, taken-branch squash.
// Latency: Mealy, controls are combinational in the same cycle. Freeze holds until mem_ready.
// HAZARD_PERF_CNT_EN builds the perf counters; otherwise the perf outputs are tied to 0.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 8     // must satisfy 2**CNT_W > MEM_TIMEOUT
) (
    input logic         clk,
    input logic         rst,
    hazard_ctrl_if.slave hif
);

    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

    state_t           state, stateNext;
    logic [CNT_W-1:0] waitCnt, waitCntNext;
    logic             timeoutErr;
    logic             luHaz, memWait, frozen;
    logic             freeze, flush, luStall;
    logic             freezeAct, flushAct, luStallAct;

    always_comb begin
        luHaz = hif.ex_mem_read && hif.ex_write_en &&
                (regHit(hif.id_uses_rs, hif.id_rs, hif.ex_rd) ||
                 regHit(hif.id_uses_rqrd, hif.id_rqrd, hif.ex_rd));
        memWait = hif.mem_req && !hif.mem_ready;
        // Once waiting, only mem_ready releases the freeze.
        frozen  = (state == MEM_WAIT) ? !hif.mem_ready : memWait;
    end

    always_comb begin
        stateNext   = RUN;
        waitCntNext = '0;
        freeze      = 1'b0;
        flush       = 1'b0;
        luStall     = 1'b0;
        if (frozen) begin
            freeze    = 1'b1;
            stateNext = MEM_WAIT;
            if (state != MEM_WAIT)
                waitCntNext = CNT_W'(1);
            else
                waitCntNext = (waitCnt == CNT_MAX) ? waitCnt : waitCnt + CNT_W'(1);
        end else if (hif.branch_taken) begin
            // A dependent consumer is squashed, so a coincident load-use is ignored.
            flush = 1'b1;
        end else if (luHaz && state != LU_STALL) begin
            luStall   = 1'b1;
            stateNext = LU_STALL;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= RUN;
            waitCnt    <= '0;
            timeoutErr <= 1'b0;
        end else begin
            state   <= stateNext;
            waitCnt <= waitCntNext;
            if (freeze && waitCntNext >= TIMEOUT_CNT) timeoutErr <= 1'b1;
        end
    end

    // Outputs are forced low while reset is held, regardless of inputs.
    assign freezeAct  = freeze  && !rst;
    assign flushAct   = flush   && !rst;
    assign luStallAct = luStall && !rst;

    assign hif.pipe_freeze     = freezeAct;
    assign hif.pc_stall        = freezeAct || luStallAct;
    assign hif.ifid_stall      = freezeAct || luStallAct;
    assign hif.idex_bubble     = flushAct || luStallAct;
    assign hif.ifid_flush      = flushAct;
    assign hif.mem_timeout_err = timeoutErr && !rst;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] luCnt, waitCyc, flushCnt;

    hazard_perf_cnt uPerfCnt (
        .clk      (clk),
        .rst      (rst),
        .luStall  (luStallAct),
        .freeze   (freezeAct),
        .flush    (flushAct),
        .luCnt    (luCnt),
        .waitCnt  (waitCyc),
        .flushCnt (flushCnt)
    );

    assign hif.perf_lu_stalls = luCnt;
    assign hif.perf_mem_wait  = waitCyc;
    assign hif.perf_flushes   = flushCnt;
`else
    assign hif.perf_lu_stalls = '0;
    assign hif.perf_mem_wait  = '0;
    assign hif.perf_flushes   = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: load-use, branch squash, memory wait, timeout and reset.
module tb_hazard_ctrl;
    import hazard_pkg::*;

`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk;
    logic rst;
    int   compared;
    int   mismatched;
    int   expLu, expMw, expFl;
    logic [5:0] o;

    hazard_ctrl_if hif ();

    hazard_ctrl #(.MEM_TIMEOUT(10), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .hif (hif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // {pc_stall, ifid_stall, idex_bubble, ifid_flush, pipe_freeze, mem_timeout_err}
    function automatic logic [5:0] outs();
        return {hif.pc_stall, hif.ifid_stall, hif.idex_bubble, hif.ifid_flush,
                hif.pipe_freeze, hif.mem_timeout_err};
    endfunction

    task automatic idle();
        hif.id_rs = '0; hif.id_rqrd = '0; hif.id_uses_rs = 1'b0; hif.id_uses_rqrd = 1'b0;
        hif.ex_rd = '0; hif.ex_mem_read = 1'b0; hif.ex_write_en = 1'b0;
        hif.branch_taken = 1'b0; hif.mem_req = 1'b0; hif.mem_ready = 1'b0;
    endtask

    task automatic loadR3();
        hif.ex_mem_read = 1'b1; hif.ex_write_en = 1'b1; hif.ex_rd = 3'd3;
    endtask

    task automatic checkPerf(input string name);
        compared++;
        if (hif.perf_lu_stalls !== (PERF ? 32'(expLu) : 32'd0)) begin
            mismatched++;
            $display("FAIL %s perf_lu_stalls: got %0d expected %0d", name, hif.perf_lu_stalls, PERF ? expLu : 0);
        end
        compared++;
        if (hif.perf_mem_wait !== (PERF ? 32'(expMw) : 32'd0)) begin
            mismatched++;
            $display("FAIL %s perf_mem_wait: got %0d expected %0d", name, hif.perf_mem_wait, PERF ? expMw : 0);
        end
        compared++;
        if (hif.perf_flushes !== (PERF ? 32'(expFl) : 32'd0)) begin
            mismatched++;
            $display("FAIL %s perf_flushes: got %0d expected %0d", name, hif.perf_flushes, PERF ? expFl : 0);
        end
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b0;
        #1 rst = 1'b1;
        @(negedge clk); @(negedge clk);
        #1 o = outs(); compared++;
        if (o !== 6'b000000) begin mismatched++; $display("FAIL reset_outs: got %b expected %b", o, 6'b000000); end
        checkPerf("reset");
        @(negedge clk); rst = 1'b0;
        #1 o = outs(); compared++;
        if (o !== 6'b000000) begin mismatched++; $display("FAIL reset_release: got %b expected %b", o, 6'b000000); end
    endtask

    task automatic test_load_use();
        @(negedge clk); idle(); loadR3(); hif.id_rs = 3'd3; hif.id_uses_rs = 1'b1;
        #1 o = outs(); compared++;
        if (o !== 6'b111000) begin mismatched++; $display("FAIL lu_stall: got %b expected %b", o, 6'b111000); end
        expLu++;
        // Hazard still visible in LU_STALL: no second stall.
        @(negedge clk);
        #1 o = outs(); compared++;
        if (o !== 6'b000000) begin mismatched++; $display("FAIL lu_no_double: got %b expected %b", o, 6'b000000); end
        checkPerf("lu_one");
        // Back in RUN, a fresh hazard stalls again.
        @(negedge clk);
        #1 o = outs(); compared++;
        if (o !== 6'b111000) begin mismatched++; $display("FAIL lu_again: got %b expected %b", o, 6'b111000); end
        expLu++;
        @(negedge clk); idle();
        #1 o = outs(); compared++;
        if (o !== 6'b000000) begin mismatched++; $display("FAIL lu_after: got %b expected %b", o, 6'b000000); end
        @(negedge clk);
    endtask

    task automatic test_no_dep();
        @(negedge clk); idle(); loadR3();
        hif.id_rs = 3'd3; hif.id_uses_rs = 1'b0; hif.id_rqrd = 3'd5; hif.id_uses_rqrd = 1'b1;
        #1 o = outs(); compared++;
        if (o !== 6'b000000) begin mismatched++; $display("FAIL nodep_unused_rs: got %b expected %b", o, 6'b000000); end
        @(negedge clk); idle(); loadR3(); hif.ex_write_en = 1'b0; hif.id_rs = 3'd3; hif.id_uses_rs = 1'b1;
        #1 o = outs(); compared++;
        if (o !== 6'b000000) begin mismatched++; $display("FAIL nodep_no_write: got %b expected %b", o, 6'b000000); end
        @(negedge clk); idle(); loadR3(); hif.id_rqrd = 3'd3; hif.id_uses_rqrd = 1'b1;
        #1 o = outs(); compared++;
        if (o !== 6'b111000) begin mismatched++; $display("FAIL dep_rqrd: got %b expected %b", o, 6'b111000); end
        expLu++;
        @(negedge clk); idle();
        @(negedge clk);
    endtask

    task automatic test_branch_lu();
        @(negedge clk); idle(); loadR3(); hif.id_rs = 3'd3; hif.id_uses_rs = 1'b1; hif.branch_taken = 1'b1;
        #1 o = outs(); compared++;
        if (o !== 6'b001100) begin mismatched++; $display("FAIL branch_over_lu: got %b expected %b", o, 6'b001100); end
        expFl++;
        // Still RUN (no LU_STALL entry): the hazard now stalls.
        @(negedge clk); hif.branch_taken = 1'b0;
        #1 o = outs(); compared++;
        if (o !== 6'b111000) begin mismatched++; $display("FAIL branch_then_lu: got %b expected %b", o, 6'b111000); end
        expLu++;
        @(negedge clk); idle();
        #1 checkPerf("branch_lu");
        @(negedge clk);
    endtask

    task automatic test_mem_wait();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); idle(); hif.mem_req = 1'b1; hif.branch_taken = (i >= 2);
            #1 o = outs(); compared++;
            if (o !== 6'b110010) begin mismatched++; $display("FAIL mem_freeze[%0d]: got %b expected %b", i, o, 6'b110010); end
            expMw++;
        end
        // Release cycle acts on the branch held during the freeze.
        @(negedge clk); hif.mem_ready = 1'b1;
        #1 o = outs(); compared++;
        if (o !== 6'b001100) begin mismatched++; $display("FAIL mem_release: got %b expected %b", o, 6'b001100); end
        expFl++;
        @(negedge clk); idle();
        #1 o = outs(); compared++;
        if (o !== 6'b000000) begin mismatched++; $display("FAIL mem_after: got %b expected %b", o, 6'b000000); end
        checkPerf("mem_wait");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); idle(); hif.branch_taken = 1'b1;
            #1 o = outs(); compared++;
            if (o !== 6'b001100) begin mismatched++; $display("FAIL b2b_flush[%0d]: got %b expected %b", i, o, 6'b001100); end
            expFl++;
        end
        @(negedge clk); hif.mem_req = 1'b1;
        #1 o = outs(); compared++;
        if (o !== 6'b110010) begin mismatched++; $display("FAIL b2b_mw_priority: got %b expected %b", o, 6'b110010); end
        expMw++;
        @(negedge clk); hif.mem_ready = 1'b1;
        #1 o = outs(); compared++;
        if (o !== 6'b001100) begin mismatched++; $display("FAIL b2b_release: got %b expected %b", o, 6'b001100); end
        expFl++;
        @(negedge clk); idle();
        #1 checkPerf("b2b");
    endtask

    task automatic test_timeout();
        logic [5:0] exp;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk); idle(); hif.mem_req = 1'b1;
            exp = (k > 10) ? 6'b110011 : 6'b110010;
            #1 o = outs(); compared++;
            if (o !== exp) begin mismatched++; $display("FAIL timeout_cyc%0d: got %b expected %b", k, o, exp); end
            expMw++;
        end
        @(negedge clk); hif.mem_ready = 1'b1;
        #1 o = outs(); compared++;
        if (o !== 6'b000001) begin mismatched++; $display("FAIL timeout_release: got %b expected %b", o, 6'b000001); end
        @(negedge clk); idle();
        #1 o = outs(); compared++;
        if (o !== 6'b000001) begin mismatched++; $display("FAIL timeout_sticky: got %b expected %b", o, 6'b000001); end
        checkPerf("timeout");
    endtask

    task automatic test_reset_mid_wait();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); idle(); hif.mem_req = 1'b1;
            #1 o = outs(); compared++;
            if (o !== 6'b110011) begin mismatched++; $display("FAIL rstwait_freeze[%0d]: got %b expected %b", i, o, 6'b110011); end
        end
        #2 rst = 1'b1;
        #1 o = outs(); compared++;
        if (o !== 6'b000000) begin mismatched++; $display("FAIL rstwait_async: got %b expected %b", o, 6'b000000); end
        expLu = 0; expMw = 0; expFl = 0;
        checkPerf("rstwait");
        @(negedge clk); idle(); rst = 1'b0;
        #1 o = outs(); compared++;
        if (o !== 6'b000000) begin mismatched++; $display("FAIL rstwait_run: got %b expected %b", o, 6'b000000); end
        // Fresh wait from RUN: freeze then clean release, error stays clear.
        @(negedge clk); hif.mem_req = 1'b1;
        #1 o = outs(); compared++;
        if (o !== 6'b110010) begin mismatched++; $display("FAIL rstwait_newfreeze: got %b expected %b", o, 6'b110010); end
        expMw++;
        @(negedge clk); hif.mem_ready = 1'b1;
        #1 o = outs(); compared++;
        if (o !== 6'b000000) begin mismatched++; $display("FAIL rstwait_newrelease: got %b expected %b", o, 6'b000000); end
        @(negedge clk); idle();
        #1 checkPerf("rstwait_after");
    endtask

    initial begin
        compared = 0; mismatched = 0;
        expLu = 0; expMw = 0; expFl = 0;
        test_reset();
        test_load_use();
        test_no_dep();
        test_branch_lu();
        test_mem_wait();
        test_back_to_back();
        test_timeout();
        test_reset_mid_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage, 8-register, 32-bit core.
- Sequences the ALU forwarding path by stalling or bubbling wherever forwarding alone cannot resolve a hazard:
  - load-use dependencies,
  - multi-cycle data-memory accesses,
  - taken-branch squashes.
- Sits beside the ID/EX stages. Drives PC/IF-ID hold, ID-EX bubble, IF-ID flush and whole-pipe freeze.

Parameters:
- REG_W, 3, register-specifier width.
- MEM_TIMEOUT, 255, memory-wait cycles before the timeout error asserts.
- CNT_W, 8, width of the memory-wait counter; must satisfy 2^CNT_W > MEM_TIMEOUT.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_rs  in  REG_W  Rs specifier of the instruction in ID.
- id_rqrd  in  REG_W  Rq/Rd source specifier of the instruction in ID.
- id_uses_rs  in  1  ID instruction reads Rs.
- id_uses_rqrd  in  1  ID instruction reads Rq/Rd.
- ex_rd  in  REG_W  destination of the instruction in EX.
- ex_mem_read  in  1  EX instruction is a load.
- ex_write_en  in  1  EX instruction writes a register.
- branch_taken  in  1  taken branch/jump resolved in EX this cycle.
- mem_req  in  1  MEM stage is issuing a data access.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_stall  out  1  hold PC.
- ifid_stall  out  1  hold the IF/ID register.
- idex_bubble  out  1  load a NOP into ID/EX.
- ifid_flush  out  1  clear IF/ID (squash).
- pipe_freeze  out  1  hold every pipeline register, including EX/MEM and MEM/WB.
- mem_timeout_err  out  1  sticky error flag.
- perf_lu_stalls  out  32  load-use stall count.
- perf_mem_wait  out  32  memory-wait cycle count.
- perf_flushes  out  32  flush count.

Behaviour:
- Reset (asynchronous):
  - state=RUN, wait counter=0, all outputs 0, perf counters 0.
  - Reset mid-wait or mid-stall abandons the operation immediately.
- State register is clocked. Outputs are combinational from the current state and inputs (Mealy).
- Hazard term: lu = ex_mem_read & ex_write_en & ((id_uses_rs & id_rs==ex_rd) | (id_uses_rqrd & id_rqrd==ex_rd)).
- mw = mem_req & ~mem_ready.
- Priority per cycle: mw > branch_taken > lu.
- RUN state:
  - mw: pipe_freeze=1, pc_stall=1, ifid_stall=1. Next state MEM_WAIT; counter<=1.
  - else branch_taken: ifid_flush=1, idex_bubble=1. Stay in RUN. A simultaneous lu is ignored because the dependent instruction is squashed.
  - else lu: pc_stall=1, ifid_stall=1, idex_bubble=1. Next state LU_STALL.
  - else all outputs 0.
- LU_STALL state (exactly one cycle):
  - The load is now in MEM; the consumer enters EX next cycle and takes the loaded value via the WB forwarding path.
  - No stall outputs are asserted for lu. lu is not re-evaluated, which prevents a double stall.
  - mw / branch_taken are handled as in RUN.
  - Otherwise next state RUN.
- MEM_WAIT state:
  - pipe_freeze=pc_stall=ifid_stall=1 while mem_ready=0.
  - Counter increments, saturating at 2^CNT_W-1.
  - When counter reaches MEM_TIMEOUT, mem_timeout_err<=1. The flag stays set until rst.
  - On mem_ready=1: freeze outputs drop that same cycle, counter<=0, next state RUN.
- branch_taken arriving while frozen:
  - It is held by the frozen EX stage and is acted upon in the first unfrozen cycle.
  - It is never acted on during a freeze (ifid_flush=0 while pipe_freeze=1).
- ifid_flush and pipe_freeze are never both 1.
- idex_bubble is never asserted while pipe_freeze=1.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined:
  - perf_lu_stalls increments on each lu stall cycle.
  - perf_mem_wait increments on each cycle with pipe_freeze=1.
  - perf_flushes increments on each ifid_flush=1 cycle.
  - All three are 32-bit, wrap modulo 2^32, and reset to 0.
- Undefined: the ports remain present and are tied to 0; no counter flops are built.

Decomposition:
- Shared package hazard_pkg:
  - state enum (RUN, LU_STALL, MEM_WAIT),
  - REG_W,
  - NOP encoding used by the ID/EX bubble.
- One sub-module: hazard_perf_cnt, holding the three perf counters and instantiated under the macro.

Test Plan:
- Load r3 in EX (ex_mem_read=1, ex_write_en=1, ex_rd=3); ID reads id_rs=3 with id_uses_rs=1 -> one cycle of pc_stall/ifid_stall/idex_bubble=1, state LU_STALL, then RUN with all outputs 0; perf_lu_stalls=1.
- Same load, but ID has id_rs=3 with id_uses_rs=0 and id_rqrd=5 -> no stall.
- lu and branch_taken in the same cycle -> ifid_flush=1, idex_bubble=1, pc_stall=0; no LU_STALL entry.
- mem_req=1, mem_ready low for 4 cycles then high -> pipe_freeze high for exactly 4 cycles and low in the mem_ready cycle; perf_mem_wait=4.
- MEM_TIMEOUT=10, mem_ready held low for 12 cycles -> mem_timeout_err rises when the counter hits 10 and stays 1 after mem_ready; clears only on rst.
- rst pulsed in the middle of MEM_WAIT -> all outputs 0 asynchronously, state RUN, counters 0.
